dtc_therm_rx: RTL
=================

Name: dtc_therm_rx

Overview:
- Receive-side decoder for the 11-bit thermometer class words produced by the split-0.875 decision-tree classifiers.
- Accepts a word over a valid/ready stream and checks that it is a legal thermometer code (contiguous ones from the LSB).
- Converts the word to a 4-bit binary class index and forwards it downstream with an error flag through a 2-stage elastic pipeline.
- Keeps saturating statistics counters for the downstream aggregation logic.

Parameters:
- W, 11, thermometer word width; the class index ranges 0..W.
- IDX_W, 4, binary index width; must satisfy 2^IDX_W > W.
- CNT_W, 16, width of the statistics counters (saturating).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_therm  in  W  thermometer word; bit 0 is the LSB of the ones run.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts the result.
- out_idx  out  IDX_W  decoded class index.
- out_err  out  1  in_therm was not a legal thermometer code.
- cnt_words  out  CNT_W  number of accepted input words, saturating.
- cnt_err  out  CNT_W  number of illegal words, saturating.
- clr_stats  in  1  synchronous clear of all statistics counters.

Behaviour:
- Reset:
  - All stage valid bits = 0, so out_valid = 0.
  - out_idx = 0, out_err = 0, cnt_words = 0, cnt_err = 0.
  - in_ready is 1 in the first cycle after rst deasserts.
  - A reset asserted mid-stream drops all words in flight; none is emitted.
- Handshake:
  - Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_idx and out_err stay stable while out_valid && !out_ready.
  - in_valid is not required to stay asserted across cycles.
- Pipeline structure:
  - S1 registers the word plus its legality bit, legal = ((t & (t+1)) == 0), computed at W+1 bits.
  - S2 registers idx = popcount(t) and err = !legal.
  - Each stage advances when it is empty or the next stage is advancing.
  - in_ready = !s1_v || (!s2_v || out_ready). This is combinational and contains no path from in_valid.
- Timing:
  - Latency is 2 cycles from input transfer to out_valid.
  - Throughput is 1 word per cycle while out_ready = 1.
  - Full (both stages occupied, out_ready = 0) gives in_ready = 0 and no loss.
  - Empty with a single word gives out_valid in exactly cycle +2.
- Decode:
  - All-zero word gives idx 0 with err 0.
  - All-ones word gives idx W with err 0.
  - For an illegal word, idx = popcount (nearest-count estimate) and err = 1.
- Statistics:
  - cnt_words increments on each input transfer.
  - cnt_err increments when S2 loads a word with err = 1.
  - Both counters hold at 2^CNT_W-1 (no wrap).
  - clr_stats takes priority over an increment in the same cycle; the result is 0.
  - clr_stats does not affect the pipeline.

Optional Feature:
- Macro: DTC_THERM_RX_HIST_EN.
- When defined:
  - Adds W+1 per-class histogram counters, each CNT_W bits and saturating.
  - Each output transfer with out_err = 0 increments hist[out_idx].
  - Extra ports: hist_sel in IDX_W, hist_val out CNT_W; hist_val is registered and shows hist[hist_sel] 1 cycle later.
  - hist_sel > W reads 0.
  - Histogram counters are cleared by rst and by clr_stats.
- When undefined:
  - No histogram storage and no hist_* ports.
  - All other behaviour is identical.

Decomposition:
- Package dtc_therm_pkg holds:
  - Constants W = 11, IDX_W = 4, CNT_W = 16.
  - typedef therm_t (logic [W-1:0]) and idx_t (logic [IDX_W-1:0]).
  - Pure functions therm_legal(therm_t) and therm_popcount(therm_t) -> idx_t.
- One sub-module, dtc_sat_counter:
  - Ports: clk, rst, clr, inc.
  - Saturating CNT_W counter.
  - Instantiated for cnt_words, cnt_err and each histogram bin.

Test Plan:
1. After reset, drive in_therm = 11'b00000011111 with in_valid for 1 cycle, out_ready = 1 -> out_valid in cycle +2, out_idx = 5, out_err = 0, cnt_words = 1.
2. Drive 12 back-to-back legal codes 0..11 (all ones = 11'b11111111111) with out_ready = 1 -> 12 consecutive outputs, idx 0..11, in_ready always 1.
3. Drive illegal word 11'b00000101111 -> out_idx = 5, out_err = 1, cnt_err = 1.
4. Hold out_ready = 0 and stream 5 words -> in_ready drops after 2 accepted, outputs stay frozen; release out_ready -> all 5 emitted in order with none lost or duplicated.
5. Preload cnt_err to 0xFFFE via 65534 errored words, then send 2 more -> cnt_err = 0xFFFF; assert clr_stats with a simultaneous errored word -> 0.
6. With DTC_THERM_RX_HIST_EN defined, send idx 3 three times and 1 illegal word, then hist_sel = 3 -> hist_val = 3 one cycle later; hist_sel = 12 -> 0.

Source files
------------

// File: rtl/dtc_therm_pkg.sv
// Shared constants, types and pure decode helpers for the thermometer-code
// receive path (dtc_therm_rx and its saturating counters).
package dtc_therm_pkg;

    localparam int W     = 11;   // thermometer word width, class index 0..W
    localparam int IDX_W = 4;    // binary class index width (2**IDX_W > W)
    localparam int CNT_W = 16;   // statistics counter width

    typedef logic [W-1:0]     therm_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // A legal code is a contiguous run of ones starting at bit 0. Adding one to
    // such a run carries out of the whole run, so t & (t+1) is zero. The sum is
    // taken at W+1 bits so that the all-ones word does not wrap back to zero.
    function automatic logic therm_legal(input therm_t t);
        logic [W:0] t_ext;
        t_ext = {1'b0, t};
        return ((t_ext & (t_ext + {{W{1'b0}}, 1'b1})) == {(W+1){1'b0}});
    endfunction

    // Number of set bits; for an illegal word this is the nearest-count estimate.
    function automatic idx_t therm_popcount(input therm_t t);
        idx_t n;
        n = {IDX_W{1'b0}};
        for (int i = 0; i < W; i++) begin
            n = n + idx_t'(t[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dtc_sat_counter.sv
// Saturating CNT_W-bit event counter.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   clr  - synchronous clear, wins over inc
//   inc  - count one event this cycle
//   cnt  - current count, holds at all-ones
module dtc_sat_counter
    import dtc_therm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: reset/clear to zero, otherwise increment until all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/dtc_therm_rx.sv
// Receive-side decoder for 11-bit thermometer class words. Each accepted word
// is checked for legality (contiguous ones from bit 0), converted to a binary
// class index and forwarded through a 2-stage elastic pipeline.
//
// Optional feature: define DTC_THERM_RX_HIST_EN to add per-class histogram
// counters and the hist_sel/hist_val read port.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input stream handshake
//   in_therm            - thermometer word (bit 0 = start of ones run)
//   out_valid/out_ready - output stream handshake
//   out_idx, out_err    - decoded class index, illegal-code flag
//   cnt_words, cnt_err  - saturating counts of accepted / illegal words
//   clr_stats           - synchronous clear of all statistics
//   hist_sel, hist_val  - (HIST_EN only) histogram bin select, registered bin value
module dtc_therm_rx
    import dtc_therm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_therm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt_words,
    output logic [CNT_W-1:0] cnt_err,
    input  logic             clr_stats
`ifdef DTC_THERM_RX_HIST_EN
    ,
    input  logic [IDX_W-1:0] hist_sel,
    output logic [CNT_W-1:0] hist_val
`endif
);

    // Stage 1: raw word and its legality bit
    logic             r_s1_v;
    logic [W-1:0]     r_s1_therm;
    logic             r_s1_legal;
    // Stage 2: decoded result presented on the output
    logic             r_s2_v;
    logic [IDX_W-1:0] r_s2_idx;
    logic             r_s2_err;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_err_load;

    // A stage may load when it is empty or its contents are leaving this cycle.
    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign w_s2_adv   = !r_s2_v || out_ready;
    assign w_s1_adv   = !r_s1_v || w_s2_adv;
    assign in_ready   = w_s1_adv;
    assign w_in_xfer  = in_valid && w_s1_adv;
    assign w_out_xfer = r_s2_v && out_ready;
    assign w_err_load = w_s2_adv && r_s1_v && !r_s1_legal;

    // Stage 1 register: capture the word and its legality check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_therm <= {W{1'b0}};
            r_s1_legal <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_therm <= in_therm;
                r_s1_legal <= therm_legal(in_therm);
            end else begin
                r_s1_therm <= r_s1_therm;
                r_s1_legal <= r_s1_legal;
            end
        end else begin
            r_s1_v     <= r_s1_v;
            r_s1_therm <= r_s1_therm;
            r_s1_legal <= r_s1_legal;
        end
    end

    // Stage 2 register: decoded index and error flag; held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v   <= 1'b0;
            r_s2_idx <= {IDX_W{1'b0}};
            r_s2_err <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_idx <= therm_popcount(r_s1_therm);
                r_s2_err <= !r_s1_legal;
            end else begin
                r_s2_idx <= r_s2_idx;
                r_s2_err <= r_s2_err;
            end
        end else begin
            r_s2_v   <= r_s2_v;
            r_s2_idx <= r_s2_idx;
            r_s2_err <= r_s2_err;
        end
    end

    assign out_valid = r_s2_v;
    assign out_idx   = r_s2_idx;
    assign out_err   = r_s2_err;

    dtc_sat_counter u_cnt_words (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (w_in_xfer),
        .cnt (cnt_words)
    );

    // Illegal words are counted as they enter stage 2.
    dtc_sat_counter u_cnt_err (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (w_err_load),
        .cnt (cnt_err)
    );

`ifdef DTC_THERM_RX_HIST_EN
    logic [CNT_W-1:0] w_hist [0:W];
    logic [CNT_W-1:0] w_hist_rd;
    logic [CNT_W-1:0] r_hist_val;

    for (genvar g = 0; g <= W; g++) begin : g_hist
        dtc_sat_counter u_bin (
            .clk (clk),
            .rst (rst),
            .clr (clr_stats),
            .inc (w_out_xfer && !r_s2_err && (r_s2_idx == IDX_W'(g))),
            .cnt (w_hist[g])
        );
    end

    // Bin select mux; selections beyond W match no bin and read as zero.
    always_comb begin
        w_hist_rd = {CNT_W{1'b0}};
        for (int i = 0; i <= W; i++) begin
            if (hist_sel == IDX_W'(i)) begin
                w_hist_rd = w_hist[i];
            end else begin
                w_hist_rd = w_hist_rd;
            end
        end
    end

    // Registered histogram read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_val <= {CNT_W{1'b0}};
        end else begin
            r_hist_val <= w_hist_rd;
        end
    end

    assign hist_val = r_hist_val;
`else
    // Output transfers only feed the histogram; nothing else consumes them.
    logic w_out_xfer_unused;
    assign w_out_xfer_unused = w_out_xfer;
`endif

endmodule
